// File: rtl/cpu8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu8_pkg
//  Description : Shared opcode, EXT sub-op, ALU op and FSM state encodings
//                for the 8-bit fetch/execute core.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu8_pkg;

    // Primary opcodes, instruction bits [15:12]
    localparam logic [3:0] c_op_ext  = 4'h0;
    localparam logic [3:0] c_op_movi = 4'h1;
    localparam logic [3:0] c_op_addi = 4'h2;
    localparam logic [3:0] c_op_cmpi = 4'h3;
    localparam logic [3:0] c_op_jmp  = 4'h4;
    localparam logic [3:0] c_op_jz   = 4'h5;
    localparam logic [3:0] c_op_jnz  = 4'h6;
    localparam logic [3:0] c_op_addr = 4'h7;
    localparam logic [3:0] c_op_subr = 4'h8;
    localparam logic [3:0] c_op_andr = 4'h9;
    localparam logic [3:0] c_op_orr  = 4'hA;
    localparam logic [3:0] c_op_xorr = 4'hB;
    localparam logic [3:0] c_op_cmpr = 4'hC;
    localparam logic [3:0] c_op_movr = 4'hD;
    localparam logic [3:0] c_op_subi = 4'hE;
    localparam logic [3:0] c_op_hlt  = 4'hF;

    // EXT sub-ops, carried in imm8[7:4]
    localparam logic [3:0] c_ext_shli = 4'h1;
    localparam logic [3:0] c_ext_shri = 4'h2;

    // Core sequencer states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // ALU operation select
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/cpu8_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu8_alu
//  Description : Combinational 8-bit ALU: add, subtract, bitwise logic,
//                logical shifts and operand pass-through, with Z and C.
//                Shift amount is b[3:0]; amounts of 8 or more yield zero.
//                For SUB, C is the unsigned borrow (a < b).
//  Revision    : 1.0  initial release
// ============================================================================
module cpu8_alu
    import cpu8_pkg::*;
(
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       zf,
    output logic       cf
);

    logic [8:0] w_sum;
    logic [8:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Operation select; bit 8 of the 9-bit difference is the borrow
    always_comb begin
        result = 8'h00;
        cf     = 1'b0;
        case (op)
            ALU_ADD:  begin result = w_sum[7:0];  cf = w_sum[8];  end
            ALU_SUB:  begin result = w_diff[7:0]; cf = w_diff[8]; end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL:  result = b[3] ? 8'h00 : (a << b[2:0]);
            ALU_SHR:  result = b[3] ? 8'h00 : (a >> b[2:0]);
            ALU_PASS: result = b;
            default:  result = 8'h00;
        endcase
    end

    assign zf = (result == 8'h00);

endmodule
`default_nettype wire

// File: rtl/cpu8_fetch_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu8_fetch_core
//  Description : Two-cycle (FETCH/EXEC) 8-bit core with four registers,
//                Z/C flags, 8-bit PC and a HALT terminal state. Instructions
//                come from an external combinational 256x16 ROM.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu8_fetch_core
    import cpu8_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
)(
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  pc,
    output logic [7:0]  r0,
    output logic [7:0]  r1,
    output logic [7:0]  r2,
    output logic [7:0]  r3,
    output logic        zf,
    output logic        cf,
    output logic        halted
);

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_regs [4];
    logic        r_zf;
    logic        r_cf;
    logic        r_halted;

    logic [3:0]  w_opcode;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    alu_op_t     w_alu_op;
    logic [7:0]  w_alu_b;
    logic [7:0]  w_alu_result;
    logic        w_alu_zf;
    logic        w_alu_cf;
    logic        w_rd_we;
    logic        w_zf_we;
    logic        w_cf_we;
    logic        w_jump;
    logic        w_halt;

    assign w_opcode = r_ir[15:12];
    assign w_rd     = r_ir[11:10];
    assign w_rs     = r_ir[9:8];
    assign w_imm    = r_ir[7:0];

    // Instruction decode: ALU op, second operand, write enables and branch
    always_comb begin
        w_alu_op = ALU_PASS;
        w_alu_b  = w_imm;
        w_rd_we  = 1'b0;
        w_zf_we  = 1'b0;
        w_cf_we  = 1'b0;
        w_jump   = 1'b0;
        w_halt   = 1'b0;
        case (w_opcode)
            c_op_ext: begin
                w_alu_b = {4'h0, w_imm[3:0]};
                if (w_imm[7:4] == c_ext_shli) begin
                    w_alu_op = ALU_SHL;
                    w_rd_we  = 1'b1;
                    w_zf_we  = 1'b1;
                end else if (w_imm[7:4] == c_ext_shri) begin
                    w_alu_op = ALU_SHR;
                    w_rd_we  = 1'b1;
                    w_zf_we  = 1'b1;
                end
            end
            c_op_movi: w_rd_we = 1'b1;
            c_op_movr: begin w_alu_b = r_regs[w_rs]; w_rd_we = 1'b1; end
            c_op_addi: begin
                w_alu_op = ALU_ADD;
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_addr: begin
                w_alu_op = ALU_ADD; w_alu_b = r_regs[w_rs];
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_subi: begin
                w_alu_op = ALU_SUB;
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_subr: begin
                w_alu_op = ALU_SUB; w_alu_b = r_regs[w_rs];
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_cmpi: begin
                w_alu_op = ALU_SUB;
                {w_zf_we, w_cf_we} = 2'b11;
            end
            c_op_cmpr: begin
                w_alu_op = ALU_SUB; w_alu_b = r_regs[w_rs];
                {w_zf_we, w_cf_we} = 2'b11;
            end
            c_op_andr: begin
                w_alu_op = ALU_AND; w_alu_b = r_regs[w_rs];
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_orr: begin
                w_alu_op = ALU_OR; w_alu_b = r_regs[w_rs];
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_xorr: begin
                w_alu_op = ALU_XOR; w_alu_b = r_regs[w_rs];
                {w_rd_we, w_zf_we, w_cf_we} = 3'b111;
            end
            c_op_jmp:  w_jump = 1'b1;
            c_op_jz:   w_jump = r_zf;
            c_op_jnz:  w_jump = ~r_zf;
            c_op_hlt:  w_halt = 1'b1;
            default:   w_halt = 1'b0;
        endcase
    end

    cpu8_alu u_alu (
        .op     (w_alu_op),
        .a      (r_regs[w_rd]),
        .b      (w_alu_b),
        .result (w_alu_result),
        .zf     (w_alu_zf),
        .cf     (w_alu_cf)
    );

    // Sequencer with PC, IR, register file, flags and halted flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= 16'h0000;
            for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= rom_data;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                        r_pc    <= w_jump ? w_imm : r_pc + 8'd1;
                        if (w_rd_we) r_regs[w_rd] <= w_alu_result;
                        if (w_zf_we) r_zf <= w_alu_zf;
                        if (w_cf_we) r_cf <= w_alu_cf;
                    end
                end
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    assign rom_addr = r_pc;
    assign pc       = r_pc;
    assign r0       = r_regs[0];
    assign r1       = r_regs[1];
    assign r2       = r_regs[2];
    assign r3       = r_regs[3];
    assign zf       = r_zf;
    assign cf       = r_cf;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: doc/cpu8_fetch_core.md
CPU8_FETCH_CORE -- requirements
Module: cpu8_fetch_core

Interface
REQ-001 Parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rom_addr  output  8  instruction address, driven combinationally from PC.
REQ-005 rom_data  input  16  instruction word from the combinational 256x16 ROM.
REQ-006 pc  output  8  current program counter.
REQ-007 r0, r1, r2, r3  output  8 each  architectural register contents.
REQ-008 zf, cf  output  1 each  zero and carry/borrow flags.
REQ-009 halted  output  1  high once HLT has executed.

Function
REQ-010 Encoding SHALL be [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8/addr8.
REQ-011 FSM states: FETCH, EXEC, HALT; FETCH->EXEC always; EXEC->HALT on HLT, else EXEC->FETCH; HALT is terminal until reset.
REQ-012 FETCH: latch rom_data into IR; PC, registers and flags unchanged.
REQ-013 EXEC: execute IR; PC <= PC+1 mod 256 unless a jump is taken; each instruction takes exactly 2 cycles.
REQ-014 0x0 EXT: imm8[7:4]=1 SHLI, =2 SHRI, with shift amount imm8[3:0] (logical, 0 fill, amount >=8 gives 0); ZF updated, CF unchanged; any other sub-op is a NOP.
REQ-015 0x1 MOVI rd<=imm8; 0xD MOVR rd<=rs; flags unchanged.
REQ-016 0x2 ADDI and 0x7 ADDR: rd<=rd+operand mod 256; CF=carry out of bit 7; ZF=(result==0).
REQ-017 0xE SUBI and 0x8 SUBR: rd<=rd-operand mod 256; CF=borrow (rd<operand, unsigned); ZF=(result==0).
REQ-018 0x3 CMPI and 0xC CMPR: flags as for subtraction; rd not written.
REQ-019 0x9 ANDR, 0xA ORR, 0xB XORR: bitwise, rd written; ZF updated; CF cleared.
REQ-020 0x4 JMP: PC<=addr8; 0x5 JZ: PC<=addr8 if ZF=1; 0x6 JNZ: PC<=addr8 if ZF=0; flags unchanged.
REQ-021 0xF HLT: PC not incremented; halted=1 from the EXEC edge onward; no further fetch or state change.
REQ-022 Flags used by JZ/JNZ SHALL be the values committed before the jump's EXEC cycle.
REQ-023 PC 8'hFF SHALL increment to 8'h00.
REQ-024 rom_addr SHALL equal pc in every state, including HALT.

Reset
REQ-025 rst asserted at any time, including mid-instruction or in HALT, SHALL immediately force state FETCH, pc=RESET_PC, IR=16'h0000, r0..r3=0, zf=0, cf=0, halted=0.
REQ-026 The first FETCH SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-027 Opcode constants, EXT sub-op codes and FSM state encodings SHALL reside in a shared package cpu8_pkg.
REQ-028 The ALU (add/sub/logic/shift, plus Z/C generation) SHALL be a purely combinational sub-module cpu8_alu; the FSM, PC, IR and register file reside in cpu8_fetch_core.

Verification
REQ-029 Reference program (00:1005 01:1407 02:1801 03:0811 04:0821 05:7100 06:C100 07:500A 08:E00C 09:500C 0A:1455 0B:400C 0C:F000): halted=1 at the 22nd edge after reset release; r0=0, r1=07, r2=01, pc=0C, zf=1.
REQ-030 Carry: MOVI R0,FF; ADDI R0,01 -> r0=00, zf=1, cf=1; then SUBI R0,01 -> r0=FF, cf=1, zf=0.
REQ-031 Shifts: MOVI R3,81; SHLI R3,1 -> r3=02; SHRI R3,9 -> r3=00, zf=1, cf unchanged.
REQ-032 PC wrap: JMP FF with NOP (0000) at FF -> pc reaches 00 and fetches address 00.
REQ-033 Reset mid-op: assert rst during an EXEC of ADDR -> all outputs return to reset values asynchronously; the program restarts at RESET_PC.
REQ-034 JNZ loop: MOVI R1,03; SUBI R1,01; JNZ back -> exactly 3 loop iterations; exit with r1=00, zf=1.
